// File: rtl/hazard_unit_if.sv
// Hazard-unit signal bundle: pipeline stage state in, forwarding/stall/flush controls out.
interface hazard_unit_if #(
  parameter int unsigned RF_ADDR_WIDTH = 5
);
  logic [RF_ADDR_WIDTH-1:0] i_RsD, i_RtD, i_RsE, i_RtE;
  logic [RF_ADDR_WIDTH-1:0] i_WriteRegE, i_WriteRegM, i_WriteRegW;
  logic                     i_RegWriteE, i_RegWriteM, i_RegWriteW;
  logic                     i_MemtoRegE, i_MemtoRegM;
  logic                     i_BranchD;
  logic                     i_MduStartE;
  logic [2:0]               o_ForwardAE, o_ForwardBE;
  logic                     o_ForwardAD, o_ForwardBD;
  logic                     o_StallF, o_StallD, o_StallE;
  logic                     o_FlushE, o_FlushM;
  logic                     o_MduDone;
  logic [15:0]              o_StallCycles;

  modport master (
    output i_RsD, i_RtD, i_RsE, i_RtE, i_WriteRegE, i_WriteRegM, i_WriteRegW,
           i_RegWriteE, i_RegWriteM, i_RegWriteW, i_MemtoRegE, i_MemtoRegM,
           i_BranchD, i_MduStartE,
    input  o_ForwardAE, o_ForwardBE, o_ForwardAD, o_ForwardBD, o_StallF, o_StallD,
           o_StallE, o_FlushE, o_FlushM, o_MduDone, o_StallCycles
  );

  modport slave (
    input  i_RsD, i_RtD, i_RsE, i_RtE, i_WriteRegE, i_WriteRegM, i_WriteRegW,
           i_RegWriteE, i_RegWriteM, i_RegWriteW, i_MemtoRegE, i_MemtoRegM,
           i_BranchD, i_MduStartE,
    output o_ForwardAE, o_ForwardBE, o_ForwardAD, o_ForwardBD, o_StallF, o_StallD,
           o_StallE, o_FlushE, o_FlushM, o_MduDone, o_StallCycles
  );
endinterface

// File: rtl/hazard_unit.sv
// Five-stage pipeline hazard unit: operand forwarding, load-use/branch stalls and a
// multi-cycle mul/div occupancy FSM that holds Execute while the op runs.
module hazard_unit #(
  parameter int unsigned RF_ADDR_WIDTH = 5,
  parameter int unsigned MDU_LATENCY   = 4
) (
  input  logic            i_CLK,
  input  logic            i_RST,
  hazard_unit_if.slave    hz
);

  localparam logic [RF_ADDR_WIDTH-1:0] Zero    = '0;
  localparam logic [3:0]               CntLoad = 4'(MDU_LATENCY - 2);

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] stall_cycles_q;
  logic        mdustall, mdu_done;
  logic        lwstall, brstall;
  logic        wr_m_ok, wr_w_ok, wr_e_ok;

  assign wr_m_ok = hz.i_RegWriteM && (hz.i_WriteRegM != Zero);
  assign wr_w_ok = hz.i_RegWriteW && (hz.i_WriteRegW != Zero);
  assign wr_e_ok = hz.i_RegWriteE && (hz.i_WriteRegE != Zero);

  assign lwstall = hz.i_MemtoRegE && (hz.i_WriteRegE != Zero) &&
                   ((hz.i_WriteRegE == hz.i_RsD) || (hz.i_WriteRegE == hz.i_RtD));

  // Branch compares in Decode, so any producer still in E, or a load still in M, must drain.
  assign brstall = hz.i_BranchD &&
                   ((wr_e_ok && ((hz.i_WriteRegE == hz.i_RsD) || (hz.i_WriteRegE == hz.i_RtD))) ||
                    (hz.i_MemtoRegM && (hz.i_WriteRegM != Zero) &&
                     ((hz.i_WriteRegM == hz.i_RsD) || (hz.i_WriteRegM == hz.i_RtD))));

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mdustall = 1'b0;
    mdu_done = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (hz.i_MduStartE) begin
          mdustall = 1'b1;
          state_d  = StBusy;
          cnt_d    = CntLoad;
        end
      end
      StBusy: begin
        if (cnt_q != 4'd0) begin
          mdustall = 1'b1;
          cnt_d    = cnt_q - 4'd1;
        end else begin
          mdu_done = 1'b1;
          state_d  = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    if (i_RST) begin
      state_d  = StIdle;
      cnt_d    = 4'd0;
    end
  end

  always_comb begin
    hz.o_ForwardAE = 3'b000;
    hz.o_ForwardBE = 3'b000;
    hz.o_ForwardAD = 1'b0;
    hz.o_ForwardBD = 1'b0;
    hz.o_StallF    = 1'b0;
    hz.o_StallD    = 1'b0;
    hz.o_StallE    = 1'b0;
    hz.o_FlushE    = 1'b0;
    hz.o_FlushM    = 1'b0;
    hz.o_MduDone   = 1'b0;
    if (!i_RST) begin
      if (wr_m_ok && (hz.i_WriteRegM == hz.i_RsE))      hz.o_ForwardAE = 3'b010;
      else if (wr_w_ok && (hz.i_WriteRegW == hz.i_RsE)) hz.o_ForwardAE = 3'b001;
      if (wr_m_ok && (hz.i_WriteRegM == hz.i_RtE))      hz.o_ForwardBE = 3'b010;
      else if (wr_w_ok && (hz.i_WriteRegW == hz.i_RtE)) hz.o_ForwardBE = 3'b001;
      hz.o_ForwardAD = wr_m_ok && (hz.i_WriteRegM == hz.i_RsD);
      hz.o_ForwardBD = wr_m_ok && (hz.i_WriteRegM == hz.i_RtD);
      hz.o_StallF    = lwstall || brstall || mdustall;
      hz.o_StallD    = lwstall || brstall || mdustall;
      hz.o_StallE    = mdustall;
      hz.o_FlushM    = mdustall;
      // A held E register must keep its op, so the bubble waits until the MDU releases E.
      hz.o_FlushE    = (lwstall || brstall) && !mdustall;
      hz.o_MduDone   = mdu_done;
    end
  end

  assign hz.o_StallCycles = stall_cycles_q;

  always_ff @(posedge i_CLK) begin
    state_q <= state_d;
    cnt_q   <= cnt_d;
    if (i_RST) begin
      stall_cycles_q <= 16'd0;
    end else if (hz.o_StallD && (stall_cycles_q != 16'hFFFF)) begin
      stall_cycles_q <= stall_cycles_q + 16'd1;
    end
  end

endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit: expectations are queued as each step is driven and
// popped for comparison once the outputs settle, before the next rising edge.
module tb_hazard_unit;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hazard_unit_if #(.RF_ADDR_WIDTH(5)) hz ();

  hazard_unit #(.RF_ADDR_WIDTH(5), .MDU_LATENCY(4)) dut (
    .i_CLK (clk),
    .i_RST (rst),
    .hz    (hz.slave)
  );

  typedef struct packed {
    logic [2:0]  ae, be;
    logic        ad, bd, stall, stall_e, flush_e, done;
    logic [15:0] cycles;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [15:0] exp_cycles = 16'd0;

  task automatic clr();
    hz.i_RsD = '0;        hz.i_RtD = '0;        hz.i_RsE = '0;        hz.i_RtE = '0;
    hz.i_WriteRegE = '0;  hz.i_WriteRegM = '0;  hz.i_WriteRegW = '0;
    hz.i_RegWriteE = 1'b0; hz.i_RegWriteM = 1'b0; hz.i_RegWriteW = 1'b0;
    hz.i_MemtoRegE = 1'b0; hz.i_MemtoRegM = 1'b0;
    hz.i_BranchD = 1'b0;  hz.i_MduStartE = 1'b0;
  endtask

  task automatic push_exp(input logic [2:0] ae, input logic [2:0] be, input logic ad,
                          input logic bd, input logic stall, input logic stall_e,
                          input logic flush_e, input logic done);
    exp_t e;
    e.ae = ae; e.be = be; e.ad = ad; e.bd = bd; e.stall = stall; e.stall_e = stall_e;
    e.flush_e = flush_e; e.done = done; e.cycles = exp_cycles;
    sb.push_back(e);
  endtask

  task automatic cmp(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  // Check settled outputs against the oldest expectation, then advance one clock.
  task automatic step(input string tag);
    exp_t e;
    #1;
    if (sb.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: scoreboard empty", tag);
    end else begin
      e = sb.pop_front();
      cmp({tag, ".fwd_ae"}, 16'(hz.o_ForwardAE), 16'(e.ae));
      cmp({tag, ".fwd_be"}, 16'(hz.o_ForwardBE), 16'(e.be));
      cmp({tag, ".fwd_ad"}, 16'(hz.o_ForwardAD), 16'(e.ad));
      cmp({tag, ".fwd_bd"}, 16'(hz.o_ForwardBD), 16'(e.bd));
      cmp({tag, ".stall_f"}, 16'(hz.o_StallF), 16'(e.stall));
      cmp({tag, ".stall_d"}, 16'(hz.o_StallD), 16'(e.stall));
      cmp({tag, ".stall_e"}, 16'(hz.o_StallE), 16'(e.stall_e));
      cmp({tag, ".flush_m"}, 16'(hz.o_FlushM), 16'(e.stall_e));
      cmp({tag, ".flush_e"}, 16'(hz.o_FlushE), 16'(e.flush_e));
      cmp({tag, ".mdu_done"}, 16'(hz.o_MduDone), 16'(e.done));
      cmp({tag, ".stall_cycles"}, hz.o_StallCycles, e.cycles);
      if (e.stall && !rst && exp_cycles != 16'hFFFF) exp_cycles = exp_cycles + 16'd1;
    end
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    clr();
    @(posedge clk);
    @(negedge clk);

    // Reset masks every hazard that is present on the inputs.
    hz.i_MemtoRegE = 1'b1; hz.i_WriteRegE = 5'd9; hz.i_RtD = 5'd9;
    hz.i_RegWriteM = 1'b1; hz.i_WriteRegM = 5'd8; hz.i_RsE = 5'd8; hz.i_MduStartE = 1'b1;
    push_exp(3'b000, 3'b000, 0, 0, 0, 0, 0, 0);
    step("reset");
    rst = 1'b0;

    clr(); hz.i_RegWriteM = 1'b1; hz.i_WriteRegM = 5'd8; hz.i_RegWriteW = 1'b1;
    hz.i_WriteRegW = 5'd8; hz.i_RsE = 5'd8;
    push_exp(3'b010, 3'b000, 0, 0, 0, 0, 0, 0);
    step("fwd_m_prio");

    clr(); hz.i_RegWriteW = 1'b1; hz.i_WriteRegW = 5'd7; hz.i_RsE = 5'd7; hz.i_RtE = 5'd7;
    hz.i_WriteRegM = 5'd7;
    push_exp(3'b001, 3'b001, 0, 0, 0, 0, 0, 0);
    step("fwd_w");

    clr(); hz.i_RegWriteM = 1'b1; hz.i_RegWriteW = 1'b1;
    push_exp(3'b000, 3'b000, 0, 0, 0, 0, 0, 0);
    step("fwd_r0");

    clr(); hz.i_RegWriteM = 1'b1; hz.i_WriteRegM = 5'd3; hz.i_RsD = 5'd3; hz.i_RtD = 5'd4;
    hz.i_RtE = 5'd3;
    push_exp(3'b000, 3'b010, 1, 0, 0, 0, 0, 0);
    step("fwd_d");

    clr(); hz.i_MemtoRegE = 1'b1; hz.i_WriteRegE = 5'd9; hz.i_RtD = 5'd9;
    push_exp(3'b000, 3'b000, 0, 0, 1, 0, 1, 0);
    step("lwstall");

    clr();
    push_exp(3'b000, 3'b000, 0, 0, 0, 0, 0, 0);
    step("lw_after");

    clr(); hz.i_BranchD = 1'b1; hz.i_RsD = 5'd5; hz.i_RegWriteE = 1'b1; hz.i_WriteRegE = 5'd5;
    push_exp(3'b000, 3'b000, 0, 0, 1, 0, 1, 0);
    step("brstall_e");

    clr(); hz.i_BranchD = 1'b1; hz.i_RsD = 5'd5; hz.i_RegWriteM = 1'b1; hz.i_WriteRegM = 5'd5;
    push_exp(3'b000, 3'b000, 1, 0, 0, 0, 0, 0);
    step("br_fwd_m");

    clr(); hz.i_BranchD = 1'b1; hz.i_RtD = 5'd6; hz.i_MemtoRegM = 1'b1;
    hz.i_RegWriteM = 1'b1; hz.i_WriteRegM = 5'd6;
    push_exp(3'b000, 3'b000, 0, 1, 1, 0, 1, 0);
    step("brstall_ld_m");

    clr(); hz.i_RsD = 5'd5; hz.i_RegWriteE = 1'b1; hz.i_WriteRegE = 5'd5;
    push_exp(3'b000, 3'b000, 0, 0, 0, 0, 0, 0);
    step("nobranch");

    // Plain MDU op, latency 4.
    clr(); hz.i_MduStartE = 1'b1;
    for (int i = 0; i < 3; i++) begin
      push_exp(3'b000, 3'b000, 0, 0, 1, 1, 0, 0);
      step("mdu_busy");
    end
    push_exp(3'b000, 3'b000, 0, 0, 0, 0, 0, 1);
    step("mdu_done");
    hz.i_MduStartE = 1'b0;
    push_exp(3'b000, 3'b000, 0, 0, 0, 0, 0, 0);
    step("mdu_idle");

    // Load-use hazard coincident with an MDU op: no flush while E is held.
    clr(); hz.i_MduStartE = 1'b1; hz.i_MemtoRegE = 1'b1; hz.i_WriteRegE = 5'd9;
    hz.i_RsD = 5'd9;
    for (int i = 0; i < 3; i++) begin
      push_exp(3'b000, 3'b000, 0, 0, 1, 1, 0, 0);
      step("mdu_lw_held");
    end
    push_exp(3'b000, 3'b000, 0, 0, 1, 0, 1, 1);
    step("mdu_lw_release");

    // New op the cycle after done.
    clr(); hz.i_MduStartE = 1'b1;
    for (int i = 0; i < 3; i++) begin
      push_exp(3'b000, 3'b000, 0, 0, 1, 1, 0, 0);
      step("mdu_b2b_busy");
    end
    hz.i_MduStartE = 1'b0;
    push_exp(3'b000, 3'b000, 0, 0, 0, 0, 0, 1);
    step("mdu_b2b_done");
    push_exp(3'b000, 3'b000, 0, 0, 0, 0, 0, 0);
    step("mdu_b2b_idle");

    // Reset during BUSY aborts the op.
    clr(); hz.i_MduStartE = 1'b1;
    push_exp(3'b000, 3'b000, 0, 0, 1, 1, 0, 0);
    step("abort_start");
    rst = 1'b1;
    push_exp(3'b000, 3'b000, 0, 0, 0, 0, 0, 0);
    step("abort_rst");
    exp_cycles = 16'd0;
    rst = 1'b0;
    hz.i_MduStartE = 1'b0;
    for (int i = 0; i < 4; i++) begin
      push_exp(3'b000, 3'b000, 0, 0, 0, 0, 0, 0);
      step("abort_after");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_unit.md
HAZARD_UNIT -- requirements
Module: hazard_unit

Interface
REQ-001 SHALL have parameter RF_ADDR_WIDTH, default 5: register-file address width.
REQ-002 SHALL have parameter MDU_LATENCY, default 4: cycles a multi-cycle mul/div op occupies Execute; legal range 2..15.
REQ-003 SHALL have port i_CLK  input  1  the single clock; all state updates on the rising edge.
REQ-004 SHALL have port i_RST  input  1  synchronous active-high reset, sampled on the i_CLK rising edge.
REQ-005 SHALL have ports i_RsD, i_RtD  input  RF_ADDR_WIDTH  Decode-stage source registers.
REQ-006 SHALL have ports i_RsE, i_RtE  input  RF_ADDR_WIDTH  Execute-stage source registers.
REQ-007 SHALL have ports i_WriteRegE, i_WriteRegM, i_WriteRegW  input  RF_ADDR_WIDTH  destination register per stage.
REQ-008 SHALL have ports i_RegWriteE, i_RegWriteM, i_RegWriteW  input  1  register-write enable per stage.
REQ-009 SHALL have ports i_MemtoRegE, i_MemtoRegM  input  1  load instruction in E / M.
REQ-010 SHALL have port i_BranchD  input  1  branch in Decode, compared in Decode.
REQ-011 SHALL have port i_MduStartE  input  1  multi-cycle op present in Execute.
REQ-012 SHALL have ports o_ForwardAE, o_ForwardBE  output  3  Execute operand select: 000 register file, 001 ResultW, 010 ALUOutM; 011-111 never driven.
REQ-013 SHALL have ports o_ForwardAD, o_ForwardBD  output  1  Decode comparator select ALUOutM.
REQ-014 SHALL have ports o_StallF, o_StallD, o_StallE  output  1  hold the F/D/E pipeline registers.
REQ-015 SHALL have ports o_FlushE, o_FlushM  output  1  insert a bubble into the E/M register.
REQ-016 SHALL have port o_MduDone  output  1  last cycle of the multi-cycle op.
REQ-017 SHALL have port o_StallCycles  output  16  count of cycles with o_StallD=1.

Function
REQ-018 o_ForwardAE SHALL be 010 when RegWriteM & WriteRegM!=0 & WriteRegM==RsE; else 001 when RegWriteW & WriteRegW!=0 & WriteRegW==RsE; else 000. o_ForwardBE uses RtE the same way. M takes priority over W.
REQ-019 o_ForwardAD SHALL be RegWriteM & WriteRegM!=0 & WriteRegM==RsD; o_ForwardBD uses RtD the same way.
REQ-020 lwstall SHALL be MemtoRegE & WriteRegE!=0 & (WriteRegE==RsD | WriteRegE==RtD).
REQ-021 brstall SHALL be BranchD & ((RegWriteE & WriteRegE!=0 & WriteRegE matches RsD or RtD) | (MemtoRegM & WriteRegM!=0 & WriteRegM matches RsD or RtD)).
REQ-022 MDU FSM SHALL have two states, IDLE and BUSY, with a 4-bit down-counter cnt.
REQ-023 In IDLE with i_MduStartE=1: mdustall=1 for that cycle; next state BUSY; cnt loads MDU_LATENCY-2.
REQ-024 In BUSY: i_MduStartE is ignored. If cnt!=0: mdustall=1 and cnt decrements. If cnt==0: mdustall=0, o_MduDone=1, next state IDLE.
REQ-025 An op entering E at cycle T SHALL have mdustall=1 in T..T+L-2 and o_MduDone=1 in T+L-1, where L=MDU_LATENCY. o_MduDone SHALL be 0 in all other cycles.
REQ-026 i_MduStartE=1 in the cycle after o_MduDone SHALL start a new operation.
REQ-027 o_StallF = o_StallD = lwstall | brstall | mdustall.
REQ-028 o_StallE = o_FlushM = mdustall.
REQ-029 o_FlushE = (lwstall | brstall) & ~mdustall; E SHALL never be flushed while held.
REQ-030 Forward and stall outputs SHALL be combinational from inputs and state. o_StallCycles SHALL be registered.
REQ-031 o_StallCycles SHALL increment on each edge where o_StallD=1 and saturate at 16'hFFFF.

Reset
REQ-032 While i_RST=1: next state IDLE, cnt<=0, o_StallCycles<=0. All forward, stall and flush outputs and o_MduDone SHALL be forced to 0 in the same cycle.
REQ-033 Reset asserted in BUSY SHALL abort the op. No o_MduDone pulse SHALL follow, and the first cycle after reset SHALL behave as IDLE.

Verification
REQ-034 RegWriteM=1, WriteRegM=8, RegWriteW=1, WriteRegW=8, RsE=8, RtE=0 -> ForwardAE=010, ForwardBE=000.
REQ-035 MemtoRegE=1, WriteRegE=9, RtD=9 -> StallF=StallD=FlushE=1 for one cycle, StallE=0; o_StallCycles +1.
REQ-036 MDU_LATENCY=4, i_MduStartE high from T, no other hazard -> StallF/D/E=FlushM=1 in T, T+1, T+2; MduDone=1 in T+3; all 0 in T+4 if i_MduStartE=0.
REQ-037 Load-use hazard coincident with cycle T of an MDU op -> FlushE=0, StallE=1 throughout; FlushE=1 only in a later cycle where mdustall=0 and the hazard persists.
REQ-038 i_RST pulsed at T+1 of an MDU op -> all outputs 0 during reset; no MduDone afterwards; o_StallCycles=0.
REQ-039 BranchD=1, RsD=5, RegWriteE=1, WriteRegE=5 -> StallD=FlushE=1. Next cycle with RegWriteM=1, WriteRegM=5 -> ForwardAD=1, no stall.
